// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: shared cpu datapath widths and writeback payload sizing.
package pipe_stage_reg_pkg;
    localparam int XLEN = 32;
    localparam int REG_ADDR_W = 5;
    localparam int WB_PAYLOAD_W = 2*XLEN + XLEN + 1 + REG_ADDR_W;
    function automatic int wb_payload_w(int xlen, int reg_addr_w);
        return 2*xlen + xlen + 1 + reg_addr_w;
    endfunction
endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: generic two-entry valid/ready skid buffer with registered in_ready.
module pipe_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic         s_valid;
    logic [W-1:0] s_data;
    logic         in_xfer;
    logic         m_open;
    assign in_ready = ~s_valid;
    assign in_xfer  = in_valid & ~s_valid;
    assign m_open   = ~out_valid | out_ready;
    // Main slot refills from skid first, so order stays FIFO.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            out_valid <= 1'b0;
            s_valid   <= 1'b0;
            out_data  <= '0;
            s_data    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            s_valid   <= 1'b0;
        end else if (m_open) begin
            out_valid <= s_valid | in_xfer;
            s_valid   <= 1'b0;
            if (s_valid) out_data <= s_data;
            else if (in_xfer) out_data <= in_data;
        end else if (in_xfer) begin
            s_valid <= 1'b1;
            s_data  <= in_data;
        end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: handshaked writeback-payload pipeline register with flush,
// optional skid buffer and saturating stall counter.
module pipe_stage_reg #(
    parameter int XLEN        = pipe_stage_reg_pkg::XLEN,
    parameter int REG_ADDR_W  = pipe_stage_reg_pkg::REG_ADDR_W,
    parameter bit SKID_EN     = 1'b1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        in_wdata,
    input  logic                   in_rd_en,
    input  logic [REG_ADDR_W-1:0]  in_rd_addr,
    input  logic [XLEN-1:0]        in_pc,
    input  logic [XLEN-1:0]        in_inst,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_wdata,
    output logic                   out_rd_en,
    output logic [REG_ADDR_W-1:0]  out_rd_addr,
    output logic [XLEN-1:0]        out_pc,
    output logic [XLEN-1:0]        out_inst,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    import pipe_stage_reg_pkg::*;
    localparam int PW = wb_payload_w(XLEN, REG_ADDR_W);
    logic [PW-1:0] in_data;
    logic [PW-1:0] out_data;
    logic          m_rd_en;
    assign in_data = {in_wdata, in_rd_en, in_rd_addr, in_pc, in_inst};
    assign {out_wdata, m_rd_en, out_rd_addr, out_pc, out_inst} = out_data;
    // A bubble must never write the register file.
    assign out_rd_en = m_rd_en & out_valid;
    generate
        if (SKID_EN) begin : g_skid
            pipe_skid_buf #(.W(PW)) u_skid (
                .clk      (clk),
                .rst      (rst),
                .flush    (flush),
                .in_valid (in_valid),
                .in_ready (in_ready),
                .in_data  (in_data),
                .out_valid(out_valid),
                .out_ready(out_ready),
                .out_data (out_data)
            );
        end else begin : g_reg
            logic          m_valid;
            logic [PW-1:0] m_data;
            assign in_ready  = ~m_valid | out_ready;
            assign out_valid = m_valid;
            assign out_data  = m_data;
            always_ff @(posedge clk or posedge rst)
                if (rst) begin
                    m_valid <= 1'b0;
                    m_data  <= '0;
                end else if (flush) begin
                    m_valid <= 1'b0;
                end else if (in_valid & in_ready) begin
                    m_valid <= 1'b1;
                    m_data  <= in_data;
                end else if (out_ready) begin
                    m_valid <= 1'b0;
                end
        end
    endgenerate
    always_ff @(posedge clk or posedge rst)
        if (rst) stall_cnt <= '0;
        else if (out_valid & ~out_ready & ~&stall_cnt) stall_cnt <= stall_cnt + STALL_CNT_W'(1);
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: drives a plain-register and a skid-buffer instance with shared
// stimulus, each checked against a FIFO-queue reference model.
module tb_pipe_stage_reg;
    typedef struct packed {
        logic [31:0] wdata;
        logic        rd_en;
        logic [4:0]  rd_addr;
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, out_ready, in_rd_en;
    logic [31:0] in_wdata, in_pc, in_inst;
    logic [4:0]  in_rd_addr;
    logic [1:0]        in_ready, out_valid, out_rd_en;
    logic [1:0][31:0]  out_wdata, out_pc, out_inst;
    logic [1:0][4:0]   out_rd_addr;
    logic [15:0] stall0;
    logic [3:0]  stall1;

    int total = 0;
    int bad = 0;
    ent_t q0[$];
    ent_t q1[$];
    ent_t last[2];
    int   cnt[2];
    int   cmax[2] = '{65535, 15};

    pipe_stage_reg #(.SKID_EN(1'b0)) u_reg (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_wdata(in_wdata), .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr),
        .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_wdata(out_wdata[0]), .out_rd_en(out_rd_en[0]), .out_rd_addr(out_rd_addr[0]),
        .out_pc(out_pc[0]), .out_inst(out_inst[0]), .stall_cnt(stall0)
    );

    pipe_stage_reg #(.SKID_EN(1'b1), .STALL_CNT_W(4)) u_skid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_wdata(in_wdata), .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr),
        .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_wdata(out_wdata[1]), .out_rd_en(out_rd_en[1]), .out_rd_addr(out_rd_addr[1]),
        .out_pc(out_pc[1]), .out_inst(out_inst[1]), .stall_cnt(stall1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int qs(input int m);
        return m != 0 ? q1.size() : q0.size();
    endfunction

    // Skid mode holds up to two entries; plain mode holds one but can accept while draining.
    function automatic logic exp_rdy(input int m);
        return m != 0 ? (q1.size() < 2) : (q0.size() == 0 || out_ready);
    endfunction

    task automatic check_all();
        for (int m = 0; m < 2; m++) begin
            logic v;
            v = qs(m) > 0;
            check($sformatf("m%0d in_ready", m), 32'(in_ready[m]), 32'(exp_rdy(m)));
            check($sformatf("m%0d out_valid", m), 32'(out_valid[m]), 32'(v));
            check($sformatf("m%0d out_rd_en", m), 32'(out_rd_en[m]), 32'(v & last[m].rd_en));
            check($sformatf("m%0d wdata", m), out_wdata[m], last[m].wdata);
            check($sformatf("m%0d rd_addr", m), 32'(out_rd_addr[m]), 32'(last[m].rd_addr));
            check($sformatf("m%0d pc", m), out_pc[m], last[m].pc);
            check($sformatf("m%0d inst", m), out_inst[m], last[m].inst);
            check($sformatf("m%0d stall_cnt", m), m != 0 ? 32'(stall1) : 32'(stall0), 32'(cnt[m]));
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        last[0] = '0;
        last[1] = '0;
        cnt[0] = 0;
        cnt[1] = 0;
    endtask

    task automatic model_edge();
        ent_t e;
        logic ix[2];
        logic ox[2];
        e = {in_wdata, in_rd_en, in_rd_addr, in_pc, in_inst};
        for (int m = 0; m < 2; m++) begin
            ix[m] = in_valid && exp_rdy(m);
            ox[m] = qs(m) > 0 && out_ready;
            if (qs(m) > 0 && !out_ready && cnt[m] < cmax[m]) cnt[m]++;
        end
        if (flush) begin
            q0.delete();
            q1.delete();
        end else begin
            if (ox[0]) void'(q0.pop_front());
            if (ix[0]) q0.push_back(e);
            if (ox[1]) void'(q1.pop_front());
            if (ix[1]) q1.push_back(e);
        end
        if (q0.size() > 0) last[0] = q0[0];
        if (q1.size() > 0) last[1] = q1[0];
    endtask

    task automatic step(input logic v, input logic r, input logic f, input logic [31:0] pc,
                        input logic [31:0] wd, input logic rd_en = 1'b1, input logic [4:0] ra = 5'd1);
        in_valid = v;
        out_ready = r;
        flush = f;
        in_pc = pc;
        in_wdata = wd;
        in_rd_en = rd_en;
        in_rd_addr = ra;
        in_inst = pc ^ 32'hdead_0000;
        #1 check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_wdata = '0;
        in_rd_en = 1'b0;
        in_rd_addr = '0;
        in_pc = '0;
        in_inst = '0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        // streaming
        step(1'b1, 1'b1, 1'b0, 32'h100, 32'hA);
        step(1'b1, 1'b1, 1'b0, 32'h104, 32'hB);
        step(1'b1, 1'b1, 1'b0, 32'h108, 32'hC);
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        // backpressure: third entry is held upstream until accepted
        step(1'b1, 1'b0, 1'b0, 32'h100, 32'hA);
        step(1'b1, 1'b0, 1'b0, 32'h104, 32'hB);
        step(1'b1, 1'b0, 1'b0, 32'h108, 32'hC);
        step(1'b1, 1'b0, 1'b0, 32'h108, 32'hC);
        step(1'b1, 1'b1, 1'b0, 32'h108, 32'hC);
        step(1'b1, 1'b1, 1'b0, 32'h108, 32'hC);
        repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        // asynchronous reset with entries held
        step(1'b1, 1'b0, 1'b0, 32'h400, 32'h4);
        step(1'b1, 1'b0, 1'b0, 32'h404, 32'h5);
        #2 rst = 1'b1;
        #1 model_reset();
        check("rst async out_valid", 32'(out_valid), 32'h0);
        check_all();
        @(negedge clk);
        rst = 1'b0;
        // flush with both slots full and a simultaneous input
        step(1'b1, 1'b0, 1'b0, 32'h200, 32'h20);
        step(1'b1, 1'b0, 1'b0, 32'h204, 32'h21);
        step(1'b1, 1'b0, 1'b1, 32'h208, 32'h22);
        repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        // bubble gating keeps rd_addr visible but drops rd_en
        step(1'b1, 1'b1, 1'b0, 32'h300, 32'h30, 1'b1, 5'd5);
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        check("bubble rd_addr", 32'(out_rd_addr[1]), 32'd5);
        // saturation of the 4-bit counter, unaffected by flush
        step(1'b1, 1'b0, 1'b0, 32'h500, 32'h50);
        repeat (20) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        check("sat stall_cnt", 32'(stall1), 32'd15);
        // random traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
                 $urandom, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, handshaked pipeline register for the CPU datapath. Generalises the fixed ALU-to-LSU stage latch.
- Carries the writeback payload between stages: write data, rd enable, rd address, pc and instruction.
- Adds valid/ready flow control, a flush that inserts a bubble, and an optional skid buffer so that in_ready is registered.
- Counts stall cycles for performance debug. Instantiated between any two stages, e.g. ALU->LSU and LSU->WB.

Parameters:
- XLEN, 32, width of wdata, pc and inst fields.
- REG_ADDR_W, 5, width of the rd address.
- SKID_EN, 1:
  - 1 = two-entry skid buffer, in_ready driven from a flop.
  - 0 = single register, in_ready combinational.
- STALL_CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  kill all held entries (branch mispredict/trap).
- in_valid  in  1  upstream presents a valid entry.
- in_ready  out  1  stage can accept an entry this cycle.
- in_wdata  in  XLEN  register write data.
- in_rd_en  in  1  register write enable.
- in_rd_addr  in  REG_ADDR_W  destination register.
- in_pc  in  XLEN  instruction pc.
- in_inst  in  XLEN  instruction word.
- out_valid  out  1  held entry valid.
- out_ready  in  1  downstream accepts the entry.
- out_wdata  out  XLEN  held write data.
- out_rd_en  out  1  held rd enable, gated by out_valid.
- out_rd_addr  out  REG_ADDR_W  held rd address.
- out_pc  out  XLEN  held pc.
- out_inst  out  XLEN  held instruction.
- stall_cnt  out  STALL_CNT_W  cycles with out_valid=1 and out_ready=0.

Behaviour:
- Reset:
  - Clock is clk. Reset is asynchronous, active-high, on port rst.
  - While rst is high, all state clears immediately: main and skid valid bits, all payload fields and stall_cnt go to 0.
  - After reset: out_valid=0, out_rd_en=0, out_wdata/out_rd_addr/out_pc/out_inst=0, stall_cnt=0.
  - in_ready=1 after reset in both modes.
- Transfer rules:
  - Input transfer happens when in_valid & in_ready.
  - Output transfer happens when out_valid & out_ready.
  - Latency is 1 cycle: an entry accepted at edge N appears on out_* after edge N when the stage was empty or draining.
- SKID_EN=0:
  - in_ready = ~out_valid | out_ready (combinational).
  - On input transfer, payload loads and out_valid sets.
  - On output transfer with no input, out_valid clears.
- SKID_EN=1 (main entry M, skid entry S):
  - in_ready = ~S.valid (registered).
  - Input arrives while M is empty, or M drains this cycle: the entry loads M.
  - Input arrives while M is full and not draining: the entry loads S.
  - M drains and S is full: S moves to M and S clears. A simultaneous input is impossible because in_ready=0.
  - No entry is dropped or duplicated. Order is strictly FIFO.
- Payload handling:
  - Payload flops load only on capture and hold otherwise.
  - out_* stay stable while out_valid & ~out_ready.
  - out_rd_en = M.rd_en & out_valid, so a bubble never writes the register file.
- Flush:
  - Flush clears M.valid and S.valid at the next edge.
  - Flush takes priority over a simultaneous input transfer: that entry is discarded and the stage is empty after the edge.
  - Payload contents are not cleared by flush.
  - in_ready: in mode 1 it returns to 1 the cycle after flush. In mode 0 it is unaffected.
- stall_cnt:
  - Increments by 1 each cycle out_valid & ~out_ready.
  - Saturates at all-ones with no wrap.
  - Cleared only by rst; unaffected by flush.
- Reset mid-operation: all entries are lost with no output transfer. Upstream must re-issue.

Decomposition:
- Shared cpu package holds XLEN, REG_ADDR_W and a wb_payload struct/concatenation width, WB_PAYLOAD_W = 2*XLEN+XLEN+1+REG_ADDR_W.
- One natural sub-module: pipe_skid_buf. It is a generic width-parametrised 2-entry valid/ready skid buffer, used when SKID_EN=1.
- The top level wraps it, adds the rd_en gating and adds the stall counter.

Test Plan:
- Reset: assert rst mid-cycle with an entry held -> out_valid, out_rd_en and stall_cnt go to 0 immediately without a clock edge; in_ready=1.
- Streaming:
  - Setup: out_ready=1; send pc=0x100,0x104,0x108 with wdata=0xA,0xB,0xC on consecutive cycles.
  - Check: each appears on out_* exactly 1 cycle later, and in_ready stays 1 throughout.
- Backpressure (SKID_EN=1):
  - Setup: hold out_ready=0 while sending 3 entries.
  - Check: the first two are held (M, S), in_ready drops to 0 after the second, and the third is held upstream.
  - Release out_ready: entries emerge in order 0x100, 0x104, 0x108. stall_cnt equals the number of stalled cycles.
- Flush:
  - Setup: M and S full, and a new in_valid in the same cycle as flush=1.
  - Check: next cycle out_valid=0, out_rd_en=0, in_ready=1, and no discarded pc ever appears.
- Bubble gating: send in_rd_en=1, rd_addr=5, then let out_valid fall -> out_rd_en=0 while out_rd_addr still reads 5.
- Saturation: with STALL_CNT_W=4, stall 20 cycles -> stall_cnt=15 and holds. A flush leaves it at 15.
